// File: rtl/algo_t1_bank_resp.sv
// Memory-side responder for one physical t1 bank: bit-masked row storage, fixed-latency reads, refresh occupancy.
// Optional collision checking and sticky error reporting when T1_RESP_COLL_CHK_EN is defined.
module algo_t1_bank_resp #(
  parameter int PHYWDTH = 64,
  parameter int NUMSROW = 4096,
  parameter int BITSROW = 12,
  parameter int DELAY   = 2,
  parameter int NUMRBNK = 2,
  parameter int BITRBNK = 1,
  parameter int BITDWSN = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               t1_readA,
  input  logic               t1_writeA,
  input  logic [BITSROW-1:0] t1_addrA,
  input  logic [PHYWDTH-1:0] t1_dinA,
  input  logic [PHYWDTH-1:0] t1_bwA,
  input  logic [BITDWSN-1:0] t1_dwsnA,
  output logic [PHYWDTH-1:0] t1_doutA,
  input  logic               t1_refrB,
  input  logic [BITRBNK-1:0] t1_bankB,
  output logic [2:0]         err,
  output logic [BITDWSN-1:0] dwsn_q
);

  localparam logic [BITSROW:0] ROW_LIM = (BITSROW+1)'(NUMSROW);

  logic [PHYWDTH-1:0] mem_q  [NUMSROW];
  logic [NUMSROW-1:0] wflag_q, wflag_d;
  logic [DELAY-1:0]   vld_q, vld_d;
  logic [PHYWDTH-1:0] data_q [DELAY];
  logic [PHYWDTH-1:0] data_d [DELAY];
  logic [2:0]         err_q, err_d;
  logic [BITDWSN-1:0] dwsn_d;

  logic               access_s, in_range_s, both_s, coll_s, wr_en_s;
  logic [PHYWDTH-1:0] row_s, rd_data_s, wr_data_s;

  // Access decode: range, refresh collision, current row contents and merged write data.
  always_comb begin
    access_s   = t1_readA | t1_writeA;
    in_range_s = ({1'b0, t1_addrA} < ROW_LIM);
    both_s     = t1_readA & t1_writeA;
    coll_s     = t1_refrB & access_s & (t1_addrA[BITRBNK-1:0] == t1_bankB)
                 & (int'(t1_bankB) < NUMRBNK);
    // Rows never written since reset read as zero; the array itself is not cleared.
    if (in_range_s && wflag_q[t1_addrA]) begin
      row_s = mem_q[t1_addrA];
    end else begin
      row_s = '0;
    end
    wr_data_s = (row_s & ~t1_bwA) | (t1_dinA & t1_bwA);
`ifdef T1_RESP_COLL_CHK_EN
    wr_en_s   = t1_writeA & in_range_s & ~coll_s;
    rd_data_s = (both_s | coll_s) ? '0 : row_s;
    err_d     = err_q | {access_s & ~in_range_s, coll_s, both_s};
`else
    wr_en_s   = t1_writeA & in_range_s;
    rd_data_s = row_s;
    err_d     = 3'b000;
`endif
  end

  // Next-state for written flags, read pipeline and tuning register.
  always_comb begin
    wflag_d = wflag_q;
    if (wr_en_s) begin
      wflag_d[t1_addrA] = 1'b1;
    end else begin
      wflag_d = wflag_q;
    end
    vld_d[0]  = t1_readA;
    data_d[0] = rd_data_s;
    for (int i = 1; i < DELAY; i++) begin
      vld_d[i]  = vld_q[i-1];
      data_d[i] = data_q[i-1];
    end
    dwsn_d = access_s ? t1_dwsnA : dwsn_q;
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wflag_q <= '0;
      vld_q   <= '0;
      err_q   <= 3'b000;
      dwsn_q  <= '0;
      for (int i = 0; i < DELAY; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      wflag_q <= wflag_d;
      vld_q   <= vld_d;
      err_q   <= err_d;
      dwsn_q  <= dwsn_d;
      for (int i = 0; i < DELAY; i++) begin
        data_q[i] <= data_d[i];
      end
    end
  end

  // Storage array; validity is tracked by wflag_q so it needs no reset.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_q[t1_addrA] <= wr_data_s;
    end
  end

  assign t1_doutA = vld_q[DELAY-1] ? data_q[DELAY-1] : '0;
  assign err      = err_q;

endmodule
